// File: rtl/mips_pkg.sv
// Shared opcodes, instruction classes and scoreboard entry type for the
// pipe_MIPS32 hazard controller.
package mips_pkg;

  localparam logic [5:0] ADD   = 6'b000000;
  localparam logic [5:0] SUB   = 6'b000001;
  localparam logic [5:0] AND   = 6'b000010;
  localparam logic [5:0] OR    = 6'b000011;
  localparam logic [5:0] SLT   = 6'b000100;
  localparam logic [5:0] MUL   = 6'b000101;
  localparam logic [5:0] LW    = 6'b001000;
  localparam logic [5:0] SW    = 6'b001001;
  localparam logic [5:0] ADDI  = 6'b001010;
  localparam logic [5:0] SUBI  = 6'b001011;
  localparam logic [5:0] SLTI  = 6'b001100;
  localparam logic [5:0] BNEQZ = 6'b001101;
  localparam logic [5:0] BEQZ  = 6'b001110;
  localparam logic [5:0] HLT   = 6'b110000;

  typedef enum logic [2:0] {NOP, RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT} itype_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rnum;
  } sb_entry_t;

  function automatic itype_e classify(input logic [5:0] op);
    case (op)
      ADD, SUB, AND, OR, SLT, MUL: return RR_ALU;
      ADDI, SUBI, SLTI:            return RM_ALU;
      LW:                          return LOAD;
      SW:                          return STORE;
      BNEQZ, BEQZ:                 return BRANCH;
      HLT:                         return HALT;
      default:                     return NOP;
    endcase
  endfunction

endpackage

// File: rtl/mips_instr_decode.sv
// Combinational register-usage decode of the IF_ID instruction word.
module mips_instr_decode
  import mips_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic        o_src1_used,
  output logic [4:0]  o_src1,
  output logic        o_src2_used,
  output logic [4:0]  o_src2,
  output logic        o_dst_used,
  output logic [4:0]  o_dst,
  output logic        o_is_hlt
);

  itype_e     w_type;
  logic [4:0] w_rs, w_rt, w_rd;

  assign w_type = classify(i_instr[31:26]);
  assign w_rs   = i_instr[25:21];
  assign w_rt   = i_instr[20:16];
  assign w_rd   = i_instr[15:11];

  assign o_src1 = w_rs;
  assign o_src2 = w_rt;
  assign o_dst  = (w_type == RR_ALU) ? w_rd : w_rt;

  // R0 is hardwired zero: never a hazard source, never a tracked destination.
  assign o_src1_used = (w_type inside {RR_ALU, RM_ALU, LOAD, STORE, BRANCH}) && (w_rs != 5'd0);
  assign o_src2_used = (w_type inside {RR_ALU, STORE}) && (w_rt != 5'd0);
  assign o_dst_used  = (w_type inside {RR_ALU, RM_ALU, LOAD}) && (o_dst != 5'd0);
  assign o_is_hlt    = (w_type == HALT);

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Interlock/scheduler: RAW stall against a 3-stage destination scoreboard,
// branch squash and sticky halt.
module mips_hazard_ctrl
  import mips_pkg::*;
#(
  parameter bit WB_WRITE_FIRST = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic             ex_taken_branch,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic             halt_pending,
  output logic [31:0]      busy_regs,
  output logic [CNT_W-1:0] stall_count
);

  logic       w_s1_used, w_s2_used, w_dst_used, w_is_hlt;
  logic [4:0] w_s1, w_s2, w_dst;
  logic       w_hazard, w_issue, w_cnt_inc;

  sb_entry_t [2:0]  r_sb;
  logic             r_halt;
  logic [CNT_W-1:0] r_cnt;

  mips_instr_decode u_dec (
    .i_instr     (id_instr),
    .o_src1_used (w_s1_used),
    .o_src1      (w_s1),
    .o_src2_used (w_s2_used),
    .o_src2      (w_s2),
    .o_dst_used  (w_dst_used),
    .o_dst       (w_dst),
    .o_is_hlt    (w_is_hlt)
  );

  function automatic logic hit(input sb_entry_t e);
    return e.valid && ((w_s1_used && e.rnum == w_s1) || (w_s2_used && e.rnum == w_s2));
  endfunction

  assign w_hazard = id_valid && (hit(r_sb[0]) || hit(r_sb[1]) ||
                                 (!WB_WRITE_FIRST && hit(r_sb[2])));

  always_comb begin
    stall     = 1'b0;
    bubble    = 1'b0;
    flush     = 1'b0;
    w_issue   = 1'b0;
    w_cnt_inc = 1'b0;
    if (!rst) begin
      if (r_halt) begin
        stall  = 1'b1;
        bubble = 1'b1;
      end else if (ex_taken_branch) begin
        flush  = 1'b1;
        bubble = 1'b1;
      end else if (w_hazard) begin
        stall     = 1'b1;
        bubble    = 1'b1;
        w_cnt_inc = 1'b1;
      end else begin
        w_issue = id_valid;
      end
    end
  end

  always_comb begin
    busy_regs = '0;
    for (int i = 0; i < 3; i++)
      if (r_sb[i].valid) busy_regs[r_sb[i].rnum] = 1'b1;
    busy_regs[0] = 1'b0;
  end

  assign halt_pending = r_halt;
  assign stall_count  = r_cnt;

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_sb   <= '0;
      r_halt <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_sb[2] <= r_sb[1];
      r_sb[1] <= r_sb[0];
      // Bubbles, flushes and empty slots all shift in an invalid entry.
      r_sb[0] <= (w_issue && w_dst_used) ? sb_entry_t'{valid: 1'b1, rnum: w_dst} : '0;
      if (w_issue && w_is_hlt) r_halt <= 1'b1;
      if (w_cnt_inc && r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Two controllers (WB write-first on / off, wide / 3-bit counter) checked
// every cycle against a register-age model; directed programs plus random.
module tb_mips_hazard_ctrl;
  import mips_pkg::*;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic        rst_v[2], vld[2], br_v[2];
  logic [31:0] ins[2];
  logic        st[2], bu[2], fl[2], hp[2];
  logic [31:0] busy[2];
  logic [15:0] cnt0;
  logic [2:0]  cnt1;

  mips_hazard_ctrl #(.WB_WRITE_FIRST(1'b1), .CNT_W(16)) u0 (
    .clk1(clk1), .rst(rst_v[0]), .id_valid(vld[0]), .id_instr(ins[0]),
    .ex_taken_branch(br_v[0]), .stall(st[0]), .bubble(bu[0]), .flush(fl[0]),
    .halt_pending(hp[0]), .busy_regs(busy[0]), .stall_count(cnt0));

  mips_hazard_ctrl #(.WB_WRITE_FIRST(1'b0), .CNT_W(3)) u1 (
    .clk1(clk1), .rst(rst_v[1]), .id_valid(vld[1]), .id_instr(ins[1]),
    .ex_taken_branch(br_v[1]), .stall(st[1]), .bubble(bu[1]), .flush(fl[1]),
    .halt_pending(hp[1]), .busy_regs(busy[1]), .stall_count(cnt1));

  int nvec = 0, nbad = 0;

  // Model: cycle in which each register's last writer issued. A writer is in
  // EX at age 1, MEM at 2, WB at 3; readable-too-early window is 1..depth.
  int last[2][32];
  bit mhalt[2];
  int mcnt[2];
  int cyc = 0;
  int cmax[2]  = '{65535, 7};
  int depth[2] = '{2, 3};
  bit issued[2], flushed[2];

  logic [31:0] prog[16];
  int plen;
  int pc[2];
  int h_st[2][32], h_fl[2][32], h_bu[2][32], h_hp[2][32], h_cnt[2][32];
  logic [31:0] h_busy[2][32];

  function automatic void dec(input logic [31:0] w, output int s1, output int s2,
                              output int d, output bit h);
    s1 = 0; s2 = 0; d = 0; h = 0;
    case (w[31:26])
      ADD, SUB, AND, OR, SLT, MUL: begin s1 = int'(w[25:21]); s2 = int'(w[20:16]); d = int'(w[15:11]); end
      ADDI, SUBI, SLTI, LW:        begin s1 = int'(w[25:21]); d = int'(w[20:16]); end
      SW:                          begin s1 = int'(w[25:21]); s2 = int'(w[20:16]); end
      BNEQZ, BEQZ:                 s1 = int'(w[25:21]);
      HLT:                         h = 1;
      default: ;
    endcase
  endfunction

  function automatic bit young(input int k, input int r);
    int age;
    age = cyc - last[k][r];
    return (r != 0) && (age >= 1) && (age <= depth[k]);
  endfunction

  function automatic void clr(input int k);
    for (int r = 0; r < 32; r++) last[k][r] = -1000;
    mhalt[k] = 0;
    mcnt[k]  = 0;
  endfunction

  task automatic model(input int k, output bit es, output bit eb, output bit ef,
                       output bit ei, output logic [31:0] eby);
    int s1, s2, d, age;
    bit h, hz;
    dec(ins[k], s1, s2, d, h);
    hz  = vld[k] && (young(k, s1) || young(k, s2));
    eby = '0;
    for (int r = 1; r < 32; r++) begin
      age = cyc - last[k][r];
      if (age >= 1 && age <= 3) eby[r] = 1'b1;
    end
    es = 0; eb = 0; ef = 0; ei = 0;
    if (rst_v[k]) ;
    else if (mhalt[k]) begin es = 1; eb = 1; end
    else if (br_v[k])  begin ef = 1; eb = 1; end
    else if (hz)       begin es = 1; eb = 1; end
    else ei = vld[k];
  endtask

  task automatic step(input int idx);
    bit es, eb, ef, ei, c3, h;
    logic [31:0] eby;
    int ac, s1, s2, d;
    @(negedge clk1);
    for (int k = 0; k < 2; k++) begin
      model(k, es, eb, ef, ei, eby);
      ac = (k == 0) ? int'(cnt0) : int'(cnt1);
      nvec++;
      if (st[k] !== es || bu[k] !== eb || fl[k] !== ef || hp[k] !== mhalt[k] ||
          busy[k] !== eby || ac != mcnt[k]) begin
        nbad++;
        $display("FAIL cycle%0d dut%0d: got st=%b bu=%b fl=%b hp=%b busy=%h cnt=%0d, want st=%b bu=%b fl=%b hp=%b busy=%h cnt=%0d",
                 cyc, k, st[k], bu[k], fl[k], hp[k], busy[k], ac, es, eb, ef, mhalt[k], eby, mcnt[k]);
      end
      h_st[k][idx] = int'(st[k]); h_fl[k][idx] = int'(fl[k]); h_bu[k][idx] = int'(bu[k]);
      h_hp[k][idx] = int'(hp[k]); h_cnt[k][idx] = ac; h_busy[k][idx] = busy[k];
      issued[k] = ei; flushed[k] = ef;
      c3 = es && !mhalt[k] && !rst_v[k];
      dec(ins[k], s1, s2, d, h);
      if (rst_v[k]) clr(k);
      else begin
        if (ei && d != 0) last[k][d] = cyc;
        if (ei && h) mhalt[k] = 1;
        if (c3 && mcnt[k] < cmax[k]) mcnt[k]++;
      end
    end
    cyc++;
    @(posedge clk1); #1;
  endtask

  task automatic pin(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin rst_v[k] = 1; vld[k] = 0; br_v[k] = 0; ins[k] = '0; end
    step(31);
    for (int k = 0; k < 2; k++) rst_v[k] = 0;
  endtask

  task automatic run(input int n, input int br_at, input int rst_at);
    pc[0] = 0; pc[1] = 0;
    for (int c = 0; c < n; c++) begin
      for (int k = 0; k < 2; k++) begin
        rst_v[k] = (c == rst_at);
        br_v[k]  = (c == br_at);
        vld[k]   = (pc[k] < plen);
        ins[k]   = vld[k] ? prog[pc[k]] : 32'h0;
      end
      step(c);
      for (int k = 0; k < 2; k++) if (issued[k] || flushed[k]) pc[k]++;
    end
    for (int k = 0; k < 2; k++) begin rst_v[k] = 0; br_v[k] = 0; end
  endtask

  function automatic logic [31:0] ri(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction
  function automatic logic [31:0] rr(input logic [5:0] op, input int rs, input int rt, input int rd);
    return {op, rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction

  function automatic int bits(input int k, input int n, input bit fld);
    int v = 0;
    for (int c = 0; c < n; c++) if ((fld ? h_st[k][c] : h_hp[k][c]) != 0) v |= (1 << c);
    return v;
  endfunction

  logic [5:0] ops[15] = '{ADD, SUB, AND, OR, SLT, MUL, LW, SW, ADDI, SUBI, SLTI,
                          BNEQZ, BEQZ, 6'b111111, 6'b010101};

  initial begin
    int r;
    logic [5:0] op;
    for (int k = 0; k < 2; k++) begin rst_v[k] = 1; vld[k] = 0; br_v[k] = 0; ins[k] = '0; clr(k); end
    repeat (2) @(posedge clk1);
    #1;
    do_reset();

    // Program with no dummies: both write-first settings.
    prog[0] = ri(ADDI, 0, 1, 10); prog[1] = ri(ADDI, 0, 2, 20); prog[2] = ri(ADDI, 0, 3, 25);
    prog[3] = rr(ADD, 1, 2, 4);   prog[4] = rr(ADD, 4, 3, 5);   prog[5] = 32'hC000_0000;
    plen = 6;
    run(12, -1, -1);
    pin("wbf1_stall_map", bits(0, 12, 1), 32'hE68);
    pin("wbf1_halt_map",  bits(0, 12, 0), 32'hE00);
    pin("wbf1_count",     h_cnt[0][11], 3);
    pin("wbf0_stall_map", bits(1, 12, 1), 32'h9D8);
    pin("wbf0_halt_map",  bits(1, 12, 0), 32'h800);
    pin("wbf0_count",     h_cnt[1][11], 5);
    do_reset();

    // R0 destination/sources never interlock.
    prog[0] = rr(ADD, 1, 2, 0); prog[1] = rr(ADD, 0, 0, 3); plen = 2;
    run(3, -1, -1);
    pin("r0_stall", h_st[0][1], 0);
    pin("r0_busy",  int'(h_busy[0][1]), 0);
    do_reset();

    // Taken branch over a hazarded instruction.
    prog[0] = ri(ADDI, 0, 1, 5); prog[1] = rr(ADD, 1, 1, 2); plen = 2;
    run(3, 1, -1);
    pin("br_flush",  h_fl[0][1], 1);
    pin("br_bubble", h_bu[0][1], 1);
    pin("br_stall",  h_st[0][1], 0);
    pin("br_busy_after", int'(h_busy[0][2]), 2);
    pin("br_count",  h_cnt[0][2], 0);
    do_reset();

    // Store data dependency on rt.
    prog[0] = ri(ADDI, 0, 5, 1); prog[1] = ri(SW, 6, 5, 0); plen = 2;
    run(3, -1, -1);
    pin("sw_stall", h_st[0][1], 1);
    pin("sw_busy",  int'(h_busy[0][1]), 32'h20);
    do_reset();

    // Reset mid-stall with a full scoreboard.
    prog[0] = ri(ADDI, 0, 1, 1); prog[1] = ri(ADDI, 0, 2, 2); prog[2] = ri(ADDI, 0, 3, 3);
    prog[3] = rr(ADD, 1, 2, 4); plen = 4;
    run(6, -1, 3);
    pin("rst_busy_before", int'(h_busy[0][3]), 32'hE);
    pin("rst_stall",       h_st[0][3], 0);
    pin("rst_busy_after",  int'(h_busy[0][4]), 0);
    pin("rst_stall_after", h_st[0][4], 0);
    pin("rst_issue_busy",  int'(h_busy[0][5]), 32'h10);

    // Random traffic, same inputs to both controllers.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      op = (r < 2) ? HLT : ops[$urandom_range(0, 14)];
      for (int k = 0; k < 2; k++) begin
        ins[k]   = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 11'($urandom)};
        vld[k]   = ($urandom_range(0, 9) < 8);
        br_v[k]  = ($urandom_range(0, 9) == 0);
        rst_v[k] = ($urandom_range(0, 99) < 2);
      end
      if (k_sync()) ;
      step(30);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  // Keep both controllers on identical random inputs.
  function automatic bit k_sync();
    ins[1] = ins[0]; vld[1] = vld[0]; br_v[1] = br_v[0]; rst_v[1] = rst_v[0];
    return 1'b0;
  endfunction

endmodule
